// File: rtl/c_realign_fifo.sv
`default_nettype none
// ============================================================================
// Module   : c_realign_fifo
// Purpose  : Halfword realignment buffer between instruction fetch and decode
//            for RV32IC. Fetch beats are split into 16-bit parcels and kept
//            in a circular queue. The queue head is decoded as one complete
//            16- or 32-bit instruction at any halfword alignment. Backpressure
//            is a valid/ready handshake. A redirect flushes the queue, and the
//            leading parcels of the first beat below the target are dropped.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            fetch_valid_i/_data_i/_ready_o - fetch beat handshake
//            flush_i, flush_pc_i  - redirect request and target PC
//            inst_valid_o, inst_o, inst_pc_o, inst_is_c_o, inst_ready_i
//                                 - instruction handshake toward decode
//            occupancy_o          - parcels currently stored
// Revision : 1.0 - initial release
// ============================================================================
module c_realign_fifo #(
  parameter int          FETCH_W  = 32,
  parameter int          DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fetch_valid_i,
  input  logic [FETCH_W-1:0]          fetch_data_i,
  output logic                        fetch_ready_o,
  input  logic                        flush_i,
  input  logic [31:0]                 flush_pc_i,
  output logic                        inst_valid_o,
  output logic [31:0]                 inst_o,
  output logic [31:0]                 inst_pc_o,
  output logic                        inst_is_c_o,
  input  logic                        inst_ready_i,
  output logic [$clog2(DEPTH_HW):0]   occupancy_o
);

  localparam int NP = FETCH_W / 16;
  localparam int AW = $clog2(DEPTH_HW);
  localparam int CW = AW + 1;
  // Width of the parcel index inside a beat (PC bits [DW:1]).
  localparam int DW = $clog2(FETCH_W / 8) - 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [15:0]   beat_parcel [NP];
  logic [15:0]   mem [DEPTH_HW];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr_p1;
  logic [CW-1:0] count;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;
  logic [31:0]   pc_q;
  logic [31:0]   pc_inc;
  logic [DW-1:0] drop_q;
  logic [15:0]   h0;
  logic [15:0]   h1;
  logic          head_is_32;
  logic          head_valid;
  logic          accept;
  logic          consume;

  generate
    for (genvar g = 0; g < NP; g++) begin : g_parcel
      assign beat_parcel[g] = fetch_data_i[g*16 +: 16];
    end
  endgenerate

  // Head decode: purely from registered state.
  assign rd_ptr_p1  = rd_ptr + AW'(1);
  assign h0         = mem[rd_ptr];
  assign h1         = mem[rd_ptr_p1];
  assign head_is_32 = (h0[1:0] == 2'b11);
  assign head_valid = head_is_32 ? (count >= CW'(2)) : (count != '0);

  assign inst_valid_o = head_valid;
  assign inst_is_c_o  = head_valid && !head_is_32;
  assign inst_pc_o    = pc_q;
  assign occupancy_o  = count;

  always_comb begin
    inst_o = NOP;
    if (head_valid) begin
      inst_o = head_is_32 ? {h1, h0} : {16'h0000, h0};
    end
  end

  // Conservative ready: pre-pop count, full beat assumed even if parcels drop.
  assign free_slots    = CW'(DEPTH_HW) - count;
  assign fetch_ready_o = (free_slots >= CW'(NP)) && !flush_i;

  assign accept  = fetch_valid_i && fetch_ready_o;
  assign consume = head_valid && inst_ready_i;

  assign push_n = accept  ? (CW'(NP) - CW'(drop_q)) : '0;
  assign pop_n  = consume ? (head_is_32 ? CW'(2) : CW'(1)) : '0;
  assign pc_inc = consume ? (head_is_32 ? 32'd4 : 32'd2) : 32'd0;

  // Parcel storage: parcels drop_q..NP-1 land at consecutive slots from wr_ptr.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      for (int j = 0; j < NP; j++) begin
        if (j >= int'(drop_q)) begin
          mem[wr_ptr + AW'(j - int'(drop_q))] <= beat_parcel[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pc_q   <= {RESET_PC[31:1], 1'b0};
      drop_q <= RESET_PC[DW:1];
    end else if (flush_i) begin
      // Redirect discards any beat or consume in this cycle.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pc_q   <= flush_pc_i & 32'hFFFF_FFFE;
      drop_q <= flush_pc_i[DW:1];
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(push_n);
        drop_q <= '0;
      end
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + push_n - pop_n;
      pc_q   <= pc_q + pc_inc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_c_realign_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_c_realign_fifo
// Purpose  : Directed self-checking bench for c_realign_fifo with a 32-bit
//            fetch instance and a 64-bit fetch instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c_realign_fifo;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          failures = 0;

  // 32-bit fetch instance
  logic        fv, fl, ir;
  logic [31:0] fd, fpc;
  logic        frdy, ivld, isc;
  logic [31:0] inst, ipc;
  logic [3:0]  occ;

  // 64-bit fetch instance
  logic        fv64, fl64, ir64;
  logic [63:0] fd64;
  logic [31:0] fpc64;
  logic        frdy64, ivld64, isc64;
  logic [31:0] inst64, ipc64;
  logic [3:0]  occ64;

  always #5 clk = ~clk;

  c_realign_fifo #(.FETCH_W(32), .DEPTH_HW(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid_i(fv), .fetch_data_i(fd), .fetch_ready_o(frdy),
    .flush_i(fl), .flush_pc_i(fpc),
    .inst_valid_o(ivld), .inst_o(inst), .inst_pc_o(ipc),
    .inst_is_c_o(isc), .inst_ready_i(ir), .occupancy_o(occ)
  );

  c_realign_fifo #(.FETCH_W(64), .DEPTH_HW(8), .RESET_PC(32'h0)) dut64 (
    .clk(clk), .reset(reset),
    .fetch_valid_i(fv64), .fetch_data_i(fd64), .fetch_ready_o(frdy64),
    .flush_i(fl64), .flush_pc_i(fpc64),
    .inst_valid_o(ivld64), .inst_o(inst64), .inst_pc_o(ipc64),
    .inst_is_c_o(isc64), .inst_ready_i(ir64), .occupancy_o(occ64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic head32(input string tag, input logic v, input logic [31:0] i,
                        input logic [31:0] pc, input logic c);
    chk({tag, ".valid"}, 64'(ivld), 64'(v));
    chk({tag, ".inst"},  64'(inst), 64'(i));
    chk({tag, ".pc"},    64'(ipc),  64'(pc));
    chk({tag, ".is_c"},  64'(isc),  64'(c));
  endtask

  task automatic head64(input string tag, input logic v, input logic [31:0] i,
                        input logic [31:0] pc, input logic c);
    chk({tag, ".valid"}, 64'(ivld64), 64'(v));
    chk({tag, ".inst"},  64'(inst64), 64'(i));
    chk({tag, ".pc"},    64'(ipc64),  64'(pc));
    chk({tag, ".is_c"},  64'(isc64),  64'(c));
  endtask

  task automatic flush32(input logic [31:0] pc);
    fl  = 1'b1;
    fpc = pc;
    step();
    fl  = 1'b0;
  endtask

  initial begin
    logic acc;
    reset = 1'b1;
    fv = 0; fl = 0; ir = 0; fd = '0; fpc = '0;
    fv64 = 0; fl64 = 0; ir64 = 0; fd64 = '0; fpc64 = '0;
    step();
    // Flush during reset is ignored.
    fl = 1'b1; fpc = 32'h42;
    step();
    fl = 1'b0;
    step();
    reset = 1'b0;

    // Reset state
    head32("reset", 1'b0, 32'h13, 32'h0, 1'b0);
    chk("reset.occ", 64'(occ), 64'd0);
    chk("reset.ready", 64'(frdy), 64'd1);
    chk("reset.occ64", 64'(occ64), 64'd0);
    chk("reset.ready64", 64'(frdy64), 64'd1);

    // Aligned mix
    ir = 1'b1;
    fv = 1'b1; fd = 32'h00A00093;
    step();
    fd = 32'h45014501;
    head32("aligned0", 1'b1, 32'h00A00093, 32'h0, 1'b0);
    step();
    fv = 1'b0;
    head32("aligned1", 1'b1, 32'h00004501, 32'h4, 1'b1);
    step();
    head32("aligned2", 1'b1, 32'h00004501, 32'h6, 1'b1);
    step();
    head32("aligned_empty", 1'b0, 32'h13, 32'h8, 1'b0);

    // Straddle
    fl = 1'b1; fpc = 32'h0;
    #1;
    chk("flush.ready_low", 64'(frdy), 64'd0);
    step();
    fl = 1'b0;
    chk("flush0.occ", 64'(occ), 64'd0);
    fv = 1'b1; fd = 32'h00934501;
    step();
    fv = 1'b0;
    head32("straddle0", 1'b1, 32'h00004501, 32'h0, 1'b1);
    step();
    head32("straddle_wait", 1'b0, 32'h13, 32'h2, 1'b0);
    chk("straddle_wait.occ", 64'(occ), 64'd1);
    step();
    chk("straddle_wait2.valid", 64'(ivld), 64'd0);
    fv = 1'b1; fd = 32'h450100A0;
    step();
    fv = 1'b0;
    head32("straddle1", 1'b1, 32'h00A00093, 32'h2, 1'b0);
    step();
    head32("straddle2", 1'b1, 32'h00004501, 32'h6, 1'b1);
    step();
    chk("straddle_end.occ", 64'(occ), 64'd0);

    // Misaligned flush
    flush32(32'h103);
    head32("mflush", 1'b0, 32'h13, 32'h102, 1'b0);
    fv = 1'b1; fd = 32'h00934501;
    step();
    chk("mflush_drop.occ", 64'(occ), 64'd1);
    chk("mflush_drop.valid", 64'(ivld), 64'd0);
    fd = 32'h123400A0;
    step();
    fv = 1'b0;
    head32("mflush0", 1'b1, 32'h00A00093, 32'h102, 1'b0);
    step();
    head32("mflush1", 1'b1, 32'h00001234, 32'h106, 1'b1);

    // Backpressure
    flush32(32'h0);
    ir = 1'b0;
    fv = 1'b1;
    fd = {16'hA004, 16'hA000}; step(); chk("bp1.occ", 64'(occ), 64'd2); chk("bp1.ready", 64'(frdy), 64'd1);
    fd = {16'hA00C, 16'hA008}; step(); chk("bp2.occ", 64'(occ), 64'd4); chk("bp2.ready", 64'(frdy), 64'd1);
    fd = {16'hA014, 16'hA010}; step(); chk("bp3.occ", 64'(occ), 64'd6); chk("bp3.ready", 64'(frdy), 64'd1);
    fd = {16'hA01C, 16'hA018}; step(); chk("bp4.occ", 64'(occ), 64'd8); chk("bp4.ready", 64'(frdy), 64'd0);
    fd = {16'hA024, 16'hA020}; step(); chk("bp_full.occ", 64'(occ), 64'd8);
    ir = 1'b1;
    for (int i = 0; i < 10; i++) begin
      head32($sformatf("bp_drain%0d", i), 1'b1, 32'hA000 + 32'(i * 4), 32'(i * 2), 1'b1);
      acc = fv && frdy;
      step();
      if (acc) fv = 1'b0;
    end
    chk("bp_end.fv_consumed", 64'(fv), 64'd0);
    chk("bp_end.occ", 64'(occ), 64'd0);
    chk("bp_end.pc", 64'(ipc), 64'h14);

    // Flush collision
    fv = 1'b1; fd = 32'h45014501;
    step();
    chk("coll_pre.valid", 64'(ivld), 64'd1);
    fd = 32'h00A00093; fl = 1'b1; fpc = 32'h40;
    #1;
    chk("coll.ready", 64'(frdy), 64'd0);
    step();
    fl = 1'b0; fv = 1'b0;
    chk("coll.occ", 64'(occ), 64'd0);
    head32("coll", 1'b0, 32'h13, 32'h40, 1'b0);
    step();
    chk("coll_after.occ", 64'(occ), 64'd0);

    // FETCH_W = 64
    ir64 = 1'b1;
    fv64 = 1'b1; fd64 = 64'h4501_00A0_0093_4505;
    step();
    fv64 = 1'b0;
    chk("w64.occ", 64'(occ64), 64'd4);
    head64("w64_0", 1'b1, 32'h00004505, 32'h0, 1'b1);
    step();
    head64("w64_1", 1'b1, 32'h00A00093, 32'h2, 1'b0);
    step();
    head64("w64_2", 1'b1, 32'h00004501, 32'h6, 1'b1);
    step();
    head64("w64_empty", 1'b0, 32'h13, 32'h8, 1'b0);
    fl64 = 1'b1; fpc64 = 32'h6;
    step();
    fl64 = 1'b0;
    fv64 = 1'b1;
    step();
    fv64 = 1'b0;
    chk("w64_drop.occ", 64'(occ64), 64'd1);
    head64("w64_drop", 1'b1, 32'h00004501, 32'h6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
